ram_port_master: RTL and testbench

Initiator-side sequencer for one port of the team's multiport RAM, which has registered outputs. It accepts read and write commands over a valid/ready stream and drives the RAM port signals (address, write data, write enable). It captures read data after the RAM's fixed one-cycle read latency and returns it on a buffered valid/ready response stream with credit-based flow control. An optional fill engine initialises the whole RAM to a constant.

---
 rtl/ram_port_master.sv | 162 ++++++++++++++++
 tb/tb_ram_port_master.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_master.sv
// Initiator sequencer for one port of the multiport RAM: commands in, buffered read responses out.
// Optional fill engine, enabled by defining RAM_PORT_MASTER_FILL_EN.
//
// state | meaning
// RUN   | accept commands while response credit is available
// FILL  | write fill_value to every address, one per cycle, ascending
module ram_port_master #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              fill_done
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = $clog2(RSP_DEPTH);

  logic              p1, p2;
  logic [CNT_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
  logic              credit_ok, cmd_fire, push, pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reads issued or sampled but not yet pushed already own a FIFO slot.
  assign credit_ok = (32'(fifo_count) + 32'(p1) + 32'(p2)) < 32'(RSP_DEPTH);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign push      = p2;
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr] : '0;

`ifdef RAM_PORT_MASTER_FILL_EN
  typedef enum logic {RUN, FILL} state_t;
  localparam logic [ADDR_W:0] FILL_ONE = 1;

  state_t            state;
  logic [ADDR_W:0]   fill_cnt;
  logic [DATA_W-1:0] fill_val;

  assign cmd_ready = (state == RUN) && !fill_start && credit_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      fill_cnt  <= '0;
      fill_val  <= '0;
      busy      <= 1'b0;
      fill_done <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      p1        <= 1'b0;
      p2        <= 1'b0;
    end else begin
      ram_we    <= 1'b0;
      fill_done <= 1'b0;
      p1        <= 1'b0;
      p2        <= p1;
      case (state)
        RUN: begin
          if (fill_start) begin
            // Address 0 is written on the accept edge so FILL spans exactly 2^ADDR_W cycles.
            state    <= FILL;
            busy     <= 1'b1;
            fill_val <= fill_value;
            fill_cnt <= FILL_ONE;
            ram_we   <= 1'b1;
            ram_addr <= '0;
            ram_din  <= fill_value;
          end else if (cmd_fire) begin
            ram_we   <= cmd_we;
            ram_addr <= cmd_addr;
            ram_din  <= cmd_wdata;
            p1       <= !cmd_we;
          end
        end
        FILL: begin
          if (fill_cnt[ADDR_W]) begin
            state     <= RUN;
            busy      <= 1'b0;
            fill_done <= 1'b1;
          end else begin
            ram_we   <= 1'b1;
            ram_addr <= fill_cnt[ADDR_W-1:0];
            ram_din  <= fill_val;
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
`else
  logic unused_fill;
  assign unused_fill = &{1'b0, fill_start, fill_value};
  assign cmd_ready   = credit_ok;
  assign busy        = 1'b0;
  assign fill_done   = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      p1       <= 1'b0;
      p2       <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      p1     <= 1'b0;
      p2     <= p1;
      if (cmd_fire) begin
        ram_we   <= cmd_we;
        ram_addr <= cmd_addr;
        ram_din  <= cmd_wdata;
        p1       <= !cmd_we;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_dout;
  end

endmodule

// File: tb/tb_ram_port_master.sv
// Directed bench for ram_port_master with a registered-output RAM model.
// Fill checks are built when RAM_PORT_MASTER_FILL_EN is defined.
module tb_ram_port_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic       ram_we;
  logic       fill_start = 1'b0;
  logic [7:0] fill_value = '0;
  logic       busy, fill_done;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [7:0] rsp_q [$];
  int         rsp_c [$];
  logic [7:0] mem [16];

  ram_port_master #(.ADDR_W(4), .DATA_W(8), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .fill_start(fill_start), .fill_value(fill_value),
    .busy(busy), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // RAM with registered output: write-then-read ordering via nonblocking updates.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      rsp_q.push_back(rsp_data);
      rsp_c.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [3:0] a, input logic [7:0] d);
    int k = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
    #1;
    while (!cmd_ready && k < 100) begin
      tick(); #1; k++;
    end
    if (!cmd_ready) check("send_timeout", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input string tag);
    int k = 0;
    while (rsp_q.size() < n && k < 200) begin
      tick(); k++;
    end
    check(tag, rsp_q.size(), n);
  endtask

  task automatic read_check(input logic [3:0] a, input logic [7:0] exp, input string tag);
    rsp_q.delete(); rsp_c.delete();
    send(1'b0, a, 8'h00);
    wait_rsp(1, {tag, "_cnt"});
    check(tag, (rsp_q.size() > 0) ? 32'(rsp_q[0]) : 32'hDEAD, 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    logic [7:0] exp3, exp12;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {ram_we, ram_addr, ram_din, rsp_valid, rsp_data, busy, fill_done}, 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();

    // Write then back-to-back read of the same address
    send(1'b1, 4'd3, 8'hA5);
    check("wr_issue", {ram_we, ram_addr, ram_din}, {1'b1, 4'd3, 8'hA5});
    send(1'b0, 4'd3, 8'h00);
    check("raw_lat_k", 32'(rsp_valid), 32'd0);
    tick();
    check("raw_lat_k1", 32'(rsp_valid), 32'd0);
    tick();
    check("raw_lat_k2", {rsp_valid, rsp_data}, {1'b1, 8'hA5});
    tick();
    check("raw_popped", 32'(rsp_valid), 32'd0);
    check("idle_we", 32'(ram_we), 32'd0);

    // Credit backpressure
    for (int i = 0; i < 6; i++) send(1'b1, 4'(i), 8'(8'h10 + i));
    tick();
    rsp_ready = 1'b0;
    rsp_q.delete(); rsp_c.delete();
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'(i);
      #1;
      check("bp_accept", 32'(cmd_ready), 32'd1);
      tick();
    end
    cmd_addr = 4'd4;
    for (int j = 0; j < 3; j++) begin
      #1;
      check("bp_full", 32'(cmd_ready), 32'd0);
      tick();
    end
    check("bp_head", {rsp_valid, rsp_data}, {1'b1, 8'h10});
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    send(1'b0, 4'd4, 8'h00);
    send(1'b0, 4'd5, 8'h00);
    wait_rsp(6, "bp_count");
    for (int i = 0; i < 6; i++)
      check("bp_order", (rsp_q.size() > i) ? 32'(rsp_q[i]) : 32'hDEAD, 32'(8'h10 + i));

    // Back-to-back reads at full throughput
    for (int i = 0; i < 16; i++) send(1'b1, 4'(i), 8'(8'h40 + i));
    tick();
    rsp_q.delete(); rsp_c.delete();
    for (int i = 0; i < 16; i++) begin
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'(i);
      #1;
      check("b2b_ready", 32'(cmd_ready), 32'd1);
      tick();
    end
    cmd_valid = 1'b0;
    wait_rsp(16, "b2b_count");
    for (int i = 0; i < 16; i++) begin
      check("b2b_data", (rsp_q.size() > i) ? 32'(rsp_q[i]) : 32'hDEAD, 32'(8'h40 + i));
      check("b2b_gap", (rsp_c.size() > i) ? 32'(rsp_c[i] - rsp_c[0]) : 32'hDEAD, 32'(i));
    end

`ifdef RAM_PORT_MASTER_FILL_EN
    // Fill with 0x3C; a second fill_start mid-fill must be ignored
    fill_start = 1'b1; fill_value = 8'h3C;
    #1;
    check("fill_gate", 32'(cmd_ready), 32'd0);
    tick();
    for (int j = 0; j < 16; j++) begin
      fill_start = (j == 8);
      fill_value = (j == 8) ? 8'hFF : 8'h3C;
      #1;
      check("fill_cycle", {busy, ram_we, cmd_ready, fill_done, ram_addr, ram_din},
            {1'b1, 1'b1, 1'b0, 1'b0, 4'(j), 8'h3C});
      tick();
    end
    fill_start = 1'b0;
    #1;
    check("fill_end", {busy, ram_we, fill_done, cmd_ready}, {1'b0, 1'b0, 1'b1, 1'b1});
    tick();
    check("fill_pulse", 32'(fill_done), 32'd0);
    read_check(4'd0, 8'h3C, "fill_rd0");
    read_check(4'd7, 8'h3C, "fill_rd7");
    read_check(4'd15, 8'h3C, "fill_rd15");

    // fill_start beats a same-cycle write
    fill_start = 1'b1; fill_value = 8'h77;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'd2; cmd_wdata = 8'h11;
    #1;
    check("conf_gate", 32'(cmd_ready), 32'd0);
    tick();
    fill_start = 1'b0;
    #1;
    k = 0;
    while (!cmd_ready && k < 40) begin
      tick(); #1; k++;
    end
    check("conf_wait", k, 32'd16);
    check("conf_done", 32'(fill_done), 32'd1);
    tick();
    cmd_valid = 1'b0;
    read_check(4'd2, 8'h11, "conf_rd2");
    read_check(4'd5, 8'h77, "conf_rd5");
    exp3 = 8'h5A; exp12 = 8'h77;
`else
    // Fill request has no effect in this build
    fill_start = 1'b1; fill_value = 8'hEE;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'd2; cmd_wdata = 8'h11;
    #1;
    check("nofill_ready", 32'(cmd_ready), 32'd1);
    tick();
    fill_start = 1'b0; cmd_valid = 1'b0;
    check("nofill_wr", {busy, fill_done, ram_we, ram_addr, ram_din}, {1'b0, 1'b0, 1'b1, 4'd2, 8'h11});
    k = 0;
    for (int j = 0; j < 18; j++) begin
      if (busy || fill_done) k++;
      tick();
    end
    check("nofill_idle", k, 32'd0);
    read_check(4'd2, 8'h11, "nofill_rd2");
    read_check(4'd5, 8'h45, "nofill_rd5");
    exp3 = 8'h43; exp12 = 8'h4C;
`endif

    // Asynchronous reset with reads in flight
    rsp_ready = 1'b0;
    send(1'b0, 4'd1, 8'h00);
    send(1'b0, 4'd9, 8'h00);
`ifdef RAM_PORT_MASTER_FILL_EN
    fill_start = 1'b1; fill_value = 8'h5A;
    tick();
    fill_start = 1'b0;
    k = 0;
    while (ram_addr != 4'd5 && k < 40) begin
      tick(); k++;
    end
    check("rst_fill_at5", {busy, ram_we, ram_addr}, {1'b1, 1'b1, 4'd5});
`endif
    #2 rst = 1'b1;
    #1;
    check("rst_async", {ram_we, ram_addr, ram_din, busy, fill_done, rsp_valid, rsp_data}, 32'd0);
    #2 rst = 1'b0;
    tick();
    rsp_q.delete(); rsp_c.delete();
    rsp_ready = 1'b1;
    repeat (4) tick();
    check("rst_no_rsp", rsp_q.size(), 32'd0);
    read_check(4'd3, exp3, "rst_rd3");
    read_check(4'd12, exp12, "rst_rd12");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
